// File: rtl/tcm_arbiter.sv
// tcm_arbiter: shares one single-ported TCM between an instruction-fetch port
// and a load/store port. Issue is combinational, response arrives one cycle
// later. Optional macro TCM_ARB_RR_EN selects round-robin tie breaking in
// IDLE; without it dbus always wins a tie.
module tcm_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_ibus_req,
  input  logic [MEM_ADDR_WIDTH+1:2] i_ibus_addr,
  output logic                      o_ibus_ack,
  output logic [31:0]               o_ibus_data,
  input  logic                      i_dbus_req,
  input  logic [MEM_ADDR_WIDTH+1:2] i_dbus_addr,
  input  logic [3:0]                i_dbus_write,
  input  logic [31:0]               i_dbus_data,
  output logic                      o_dbus_ack,
  output logic [31:0]               o_dbus_data,
  output logic                      o_tcm_sel,
  output logic [MEM_ADDR_WIDTH+1:2] o_tcm_addr,
  output logic [3:0]                o_tcm_write,
  output logic [31:0]               o_tcm_data,
  input  logic [31:0]               i_tcm_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND_I = 2'd1,
    ST_PEND_D = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   elig_i;
  logic   elig_d;
  logic   grant_i;
  logic   grant_d;

`ifdef TCM_ARB_RR_EN
  // 1 when dbus was the most recent winner; reset value lets dbus win first
  logic last_d;

  // Round-robin pointer, updated on every issue
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_d <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_d <= grant_d;
    end
  end
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and next state; the port awaiting its ack is masked
  always_comb begin
    elig_i     = i_ibus_req && (state != ST_PEND_I);
    elig_d     = i_dbus_req && (state != ST_PEND_D);
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    state_next = ST_IDLE;
    if (elig_i && elig_d) begin
`ifdef TCM_ARB_RR_EN
      grant_i = last_d;
      grant_d = !last_d;
`else
      grant_d = 1'b1;
`endif
    end else begin
      grant_i = elig_i;
      grant_d = elig_d;
    end
    if (grant_d) begin
      state_next = ST_PEND_D;
    end else if (grant_i) begin
      state_next = ST_PEND_I;
    end
  end

  // Outputs: TCM issue from the winner, responses decoded from state
  always_comb begin
    o_tcm_sel   = 1'b0;
    o_tcm_addr  = i_ibus_addr;
    o_tcm_write = 4'b0000;
    o_tcm_data  = i_dbus_data;
    o_ibus_ack  = 1'b0;
    o_ibus_data = 32'd0;
    o_dbus_ack  = 1'b0;
    o_dbus_data = 32'd0;
    // Reset gates issue so no select or write strobe escapes while held
    if (i_reset_n) begin
      o_tcm_sel = grant_i || grant_d;
      if (grant_d) begin
        o_tcm_addr  = i_dbus_addr;
        o_tcm_write = i_dbus_write;
      end
    end
    if (state == ST_PEND_I) begin
      o_ibus_ack  = 1'b1;
      o_ibus_data = i_tcm_data;
    end
    if (state == ST_PEND_D) begin
      o_dbus_ack  = 1'b1;
      o_dbus_data = i_tcm_data;
    end
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// tb_tcm_arbiter: directed scenarios followed by random two-port traffic,
// checked against a transaction-level model of the arbitration rules and a
// word-array image of the TCM contents.
module tb_tcm_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          ibus_req;
  logic [AW+1:2] ibus_addr;
  logic          ibus_ack;
  logic [31:0]   ibus_rdata;
  logic          dbus_req;
  logic [AW+1:2] dbus_addr;
  logic [3:0]    dbus_write;
  logic [31:0]   dbus_data;
  logic          dbus_ack;
  logic [31:0]   dbus_rdata;
  logic          tcm_sel;
  logic [AW+1:2] tcm_addr;
  logic [3:0]    tcm_write;
  logic [31:0]   tcm_wdata;
  logic [31:0]   tcm_rdata;

  // TCM environment with a preload port
  logic          load_en;
  logic [AW+1:2] load_addr;
  logic [31:0]   load_data;
  logic [31:0]   tcm_mem [DEPTH];

  // Reference model state
  logic [31:0]   ref_mem [DEPTH];
  bit            m_ack_i;
  bit            m_ack_d;
  logic [31:0]   m_data_i;
  logic [31:0]   m_data_d;
  bit            m_last_d;

  // Observations from the latest cycle
  logic          obs_sel;
  logic [AW+1:2] obs_addr;
  logic [3:0]    obs_write;
  logic          obs_ack_i;
  logic          obs_ack_d;
  logic [31:0]   obs_data_i;
  logic [31:0]   obs_data_d;

  int checks;
  int errors;

  tcm_arbiter #(.MEM_ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_ibus_req  (ibus_req),
    .i_ibus_addr (ibus_addr),
    .o_ibus_ack  (ibus_ack),
    .o_ibus_data (ibus_rdata),
    .i_dbus_req  (dbus_req),
    .i_dbus_addr (dbus_addr),
    .i_dbus_write(dbus_write),
    .i_dbus_data (dbus_data),
    .o_dbus_ack  (dbus_ack),
    .o_dbus_data (dbus_rdata),
    .o_tcm_sel   (tcm_sel),
    .o_tcm_addr  (tcm_addr),
    .o_tcm_write (tcm_write),
    .o_tcm_data  (tcm_wdata),
    .i_tcm_data  (tcm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    merge = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge[8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  // Synchronous single-port TCM: read data one cycle after select, pre-write value
  always @(posedge clk) begin
    if (load_en) begin
      tcm_mem[load_addr] <= load_data;
    end else if (tcm_sel) begin
      tcm_rdata          <= tcm_mem[tcm_addr];
      tcm_mem[tcm_addr]  <= merge(tcm_mem[tcm_addr], tcm_wdata, tcm_write);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict winner and responses, compare at negedge, commit at posedge
  task automatic cycle(output bit gi, output bit gd);
    bit          ci;
    bit          cd;
    logic [31:0] nd_i;
    logic [31:0] nd_d;
    @(negedge clk);
    ci = ibus_req && !m_ack_i;
    cd = dbus_req && !m_ack_d;
    gi = 1'b0;
    gd = 1'b0;
    if (ci && cd) begin
`ifdef TCM_ARB_RR_EN
      gd = !m_last_d;
      gi = m_last_d;
`else
      gd = 1'b1;
`endif
    end else begin
      gi = ci;
      gd = cd;
    end
    obs_sel    = tcm_sel;
    obs_addr   = tcm_addr;
    obs_write  = tcm_write;
    obs_ack_i  = ibus_ack;
    obs_ack_d  = dbus_ack;
    obs_data_i = ibus_rdata;
    obs_data_d = dbus_rdata;
    chk("tcm_sel", 32'(tcm_sel), 32'(gi || gd));
    if (gi || gd) chk("tcm_addr", 32'(tcm_addr), gd ? 32'(dbus_addr) : 32'(ibus_addr));
    chk("tcm_write", 32'(tcm_write), gd ? 32'(dbus_write) : 32'd0);
    chk("tcm_data", tcm_wdata, dbus_data);
    chk("ibus_ack", 32'(ibus_ack), 32'(m_ack_i));
    chk("ibus_data", ibus_rdata, m_ack_i ? m_data_i : 32'd0);
    chk("dbus_ack", 32'(dbus_ack), 32'(m_ack_d));
    chk("dbus_data", dbus_rdata, m_ack_d ? m_data_d : 32'd0);
    chk("dual_ack", 32'(ibus_ack && dbus_ack), 32'd0);
    nd_i = ref_mem[ibus_addr];
    nd_d = ref_mem[dbus_addr];
    if (gd) ref_mem[dbus_addr] = merge(nd_d, dbus_data, dbus_write);
    @(posedge clk);
    #1;
    m_ack_i = gi;
    m_ack_d = gd;
    if (gi) m_data_i = nd_i;
    if (gd) m_data_d = nd_d;
    if (gi || gd) m_last_d = gd;
  endtask

  initial begin : main
    bit            gi;
    bit            gd;
    bit            act_i;
    bit            act_d;
    bit            iss_i;
    bit            iss_d;
    logic [31:0]   val;
    checks    = 0;
    errors    = 0;
    m_ack_i   = 1'b0;
    m_ack_d   = 1'b0;
    m_data_i  = 32'd0;
    m_data_d  = 32'd0;
    m_last_d  = 1'b0;
    rst_n     = 1'b0;
    ibus_req  = 1'b0;
    ibus_addr = '0;
    dbus_addr = '0;
    dbus_data = 32'd0;
    // Hold a write request through reset: nothing may reach the TCM
    dbus_req   = 1'b1;
    dbus_write = 4'hF;
    load_en    = 1'b1;
    load_addr  = '0;
    load_data  = 32'd0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      val = $urandom;
      if (a == 16) val = 32'h0000_0013;
      if (a == 32) val = 32'h1122_3344;
      load_addr  = AW'(a);
      load_data  = val;
      ref_mem[a] = val;
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    @(negedge clk);
    chk("rst_sel", 32'(tcm_sel), 32'd0);
    chk("rst_write", 32'(tcm_write), 32'd0);
    chk("rst_ibus_ack", 32'(ibus_ack), 32'd0);
    chk("rst_dbus_ack", 32'(dbus_ack), 32'd0);
    chk("rst_ibus_data", ibus_rdata, 32'd0);
    chk("rst_dbus_data", dbus_rdata, 32'd0);
    @(posedge clk);
    #1;
    dbus_req   = 1'b0;
    dbus_write = 4'h0;
    rst_n      = 1'b1;

    // First cycle out of reset: nothing pending, no ack
    cycle(gi, gd);
    chk("post_rst_ack", 32'({obs_ack_i, obs_ack_d}), 32'd0);

    // Fetch alone: one access every two cycles
    ibus_req  = 1'b1;
    ibus_addr = AW'(8'h10);
    for (int k = 0; k < 6; k++) begin
      cycle(gi, gd);
      chk("fetch_sel", 32'(obs_sel), 32'(k % 2 == 0));
      chk("fetch_ack", 32'(obs_ack_i), 32'(k % 2 == 1));
      chk("fetch_data", obs_data_i, (k % 2 == 1) ? 32'h0000_0013 : 32'd0);
    end
    ibus_req = 1'b0;

    // Partial store then read back
    dbus_req   = 1'b1;
    dbus_addr  = AW'(8'h20);
    dbus_write = 4'b0011;
    dbus_data  = 32'hAABB_CCDD;
    cycle(gi, gd);
    chk("store_issue", 32'({obs_sel, obs_write}), 32'h13);
    cycle(gi, gd);
    chk("store_ack", 32'(obs_ack_d), 32'd1);
    chk("store_old", obs_data_d, 32'h1122_3344);
    dbus_write = 4'b0000;
    dbus_data  = 32'd0;
    cycle(gi, gd);
    cycle(gi, gd);
    chk("load_back", obs_data_d, 32'h1122_CCDD);

    // Reset while a write is awaiting its ack
    dbus_addr  = AW'(8'h30);
    dbus_write = 4'hF;
    dbus_data  = 32'hCAFE_F00D;
    cycle(gi, gd);
    rst_n = 1'b0;
    #1;
    chk("midrst_dbus_ack", 32'(dbus_ack), 32'd0);
    chk("midrst_dbus_data", dbus_rdata, 32'd0);
    chk("midrst_write", 32'(tcm_write), 32'd0);
    m_ack_i  = 1'b0;
    m_ack_d  = 1'b0;
    m_last_d = 1'b0;
    dbus_req   = 1'b0;
    dbus_write = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(gi, gd);
    chk("release_no_ack", 32'({obs_ack_i, obs_ack_d}), 32'd0);

    // Both requesting: dbus first, then strict alternation
    ibus_req   = 1'b1;
    ibus_addr  = AW'(8'h04);
    dbus_req   = 1'b1;
    dbus_addr  = AW'(8'h08);
    dbus_write = 4'h0;
    for (int k = 0; k < 6; k++) begin
      cycle(gi, gd);
      chk("both_sel", 32'(obs_sel), 32'd1);
      chk("both_addr", 32'(obs_addr), (k % 2 == 0) ? 32'h08 : 32'h04);
      chk("both_ack_d", 32'(obs_ack_d), 32'(k % 2 == 1));
      chk("both_ack_i", 32'(obs_ack_i), 32'(k % 2 == 0 && k > 0));
    end
    dbus_req = 1'b0;
    cycle(gi, gd);
    ibus_req = 1'b0;
    cycle(gi, gd);

    // Fetch pulsed for one cycle while losing to dbus: silently dropped
    ibus_req  = 1'b1;
    ibus_addr = AW'(8'h44);
    dbus_req  = 1'b1;
    dbus_addr = AW'(8'h48);
    cycle(gi, gd);
    chk("pulse_winner", 32'(obs_addr), 32'h48);
    ibus_req = 1'b0;
    cycle(gi, gd);
    chk("pulse_no_issue", 32'(obs_sel), 32'd0);
    dbus_req = 1'b0;
    cycle(gi, gd);
    chk("pulse_no_ack", 32'(obs_ack_i), 32'd0);

    // Random traffic: requests held until ack, occasionally abandoned before issue
    act_i = 1'b0;
    act_d = 1'b0;
    iss_i = 1'b0;
    iss_d = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!act_i) begin
        if ($urandom % 3 == 0) begin
          act_i     = 1'b1;
          ibus_addr = AW'($urandom_range(0, 15));
        end
      end else if (!iss_i && ($urandom % 8 == 0)) begin
        act_i = 1'b0;
      end
      if (!act_d) begin
        if ($urandom % 3 == 0) begin
          act_d      = 1'b1;
          dbus_addr  = AW'($urandom_range(0, 15));
          dbus_write = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
          dbus_data  = $urandom;
        end
      end else if (!iss_d && ($urandom % 8 == 0)) begin
        act_d = 1'b0;
      end
      ibus_req = act_i;
      dbus_req = act_d;
      cycle(gi, gd);
      if (obs_ack_i === 1'b1 && iss_i) begin
        act_i = 1'b0;
        iss_i = 1'b0;
      end
      if (obs_ack_d === 1'b1 && iss_d) begin
        act_d = 1'b0;
        iss_d = 1'b0;
      end
      if (gi) iss_i = 1'b1;
      if (gd) iss_d = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
